// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - time-multiplexed 4-digit seven-segment scan controller
//
// Drives a 4-digit common-anode display through one shared external
// binary_to_seven_segment decoder. The 16-bit display value is double
// buffered, so a new value is only taken at a frame boundary and a digit
// never changes in the middle of a frame.
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= 4)
//   DEAD_CYCLES  dark cycles at the start of each slot (1 .. REFRESH_DIV-1)
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   enable      1 = scan, 0 = display dark and scanner parked
//   value_in    four hex digits, digit 0 = [3:0] = rightmost
//   dp_in       per-digit decimal point request, active-high
//   load        one-cycle strobe capturing value_in/dp_in
//   hex_in      decoded pattern for dig_bin, active-low
//   dig_bin     nibble of the current digit, to the decoder
//   an_out      anode enables, active-low
//   seg_out     cathodes, active-low
//   dp_out      decimal point cathode, active-low
//   frame_tick  one-cycle pulse after every frame boundary
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits 3..1 are blanked

module seven_segment_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic [6:0]  hex_in,
    output logic [3:0]  dig_bin,
    output logic [3:0]  an_out,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic        frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DEAD  = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic          boundary;

    logic [15:0]   pend_val, pend_val_nxt;
    logic [3:0]    pend_dp, pend_dp_nxt;
    logic          pend_vld, pend_vld_nxt;
    logic [15:0]   disp_val, disp_val_nxt;
    logic [3:0]    disp_dp, disp_dp_nxt;

    logic          lz_blank;
    logic          drive_nxt;
    logic          seg_on;

    // Slot sequencing
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        boundary  = 1'b0;
        if (!enable) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_DEAD;
                    cnt_nxt   = '0;
                    idx_nxt   = 2'd0;
                end
                S_DEAD: begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == DEAD_LAST) begin
                        state_nxt = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = S_DEAD;
                        cnt_nxt   = '0;
                        idx_nxt   = idx + 2'd1;
                        boundary  = (idx == 2'd3);
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = 2'd0;
                end
            endcase
        end
    end

    // Double buffer: loads park in pend until the frame boundary, except
    // while parked (nothing to tear) or when the load lands on the boundary.
    always_comb begin
        pend_val_nxt = pend_val;
        pend_dp_nxt  = pend_dp;
        pend_vld_nxt = pend_vld;
        disp_val_nxt = disp_val;
        disp_dp_nxt  = disp_dp;
        if (load) begin
            pend_val_nxt = value_in;
            pend_dp_nxt  = dp_in;
        end
        if ((state == S_IDLE) && load) begin
            disp_val_nxt = value_in;
            disp_dp_nxt  = dp_in;
            pend_vld_nxt = 1'b0;
        end else if (boundary) begin
            if (load) begin
                disp_val_nxt = value_in;
                disp_dp_nxt  = dp_in;
            end else if (pend_vld) begin
                disp_val_nxt = pend_val;
                disp_dp_nxt  = pend_dp;
            end
            pend_vld_nxt = 1'b0;
        end else if (load) begin
            pend_vld_nxt = 1'b1;
        end
    end

    // Outputs are computed from next-state values so that dig_bin, anodes
    // and the blank flag all change on the same edge as idx.
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        case (idx_nxt)
            2'd3:    lz_blank = (disp_val_nxt[15:12] == 4'h0);
            2'd2:    lz_blank = (disp_val_nxt[15:8] == 8'h00);
            2'd1:    lz_blank = (disp_val_nxt[15:4] == 12'h000);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    assign drive_nxt = (state_nxt == S_DRIVE) && !lz_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= 2'd0;
            pend_val   <= 16'h0000;
            pend_dp    <= 4'h0;
            pend_vld   <= 1'b0;
            disp_val   <= 16'h0000;
            disp_dp    <= 4'h0;
            an_out     <= 4'hF;
            dp_out     <= 1'b1;
            dig_bin    <= 4'h0;
            seg_on     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            pend_val   <= pend_val_nxt;
            pend_dp    <= pend_dp_nxt;
            pend_vld   <= pend_vld_nxt;
            disp_val   <= disp_val_nxt;
            disp_dp    <= disp_dp_nxt;
            an_out     <= drive_nxt ? ~(4'b0001 << idx_nxt) : 4'hF;
            dp_out     <= drive_nxt ? ~disp_dp_nxt[idx_nxt] : 1'b1;
            dig_bin    <= disp_val_nxt[{idx_nxt, 2'b00} +: 4];
            seg_on     <= drive_nxt;
            frame_tick <= boundary;
        end
    end

    assign seg_out = seg_on ? hex_in : 7'h7F;

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display. It shares the single `binary_to_seven_segment` decoder among four digits. It presents one nibble at a time on `dig_bin`, takes the decoded pattern back on `hex_in`, and drives active-low anodes, cathodes and decimal point. It sits between the FSM/counter logic that produces a 16-bit display value and the board pins, and it double-buffers the value so a digit never changes mid-frame.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot; legal range ≥ 4.
- `DEAD_CYCLES`, 1000: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 1 ≤ DEAD_CYCLES < REFRESH_DIV.
- `clk` in 1: system clock, single domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: 1 = scan; 0 = display dark, scanner parked.
- `value_in` in 16: four hex digits; digit 0 = `[3:0]` = rightmost.
- `dp_in` in 4: decimal point request per digit, active-high, sampled with `value_in`.
- `load` in 1: one-cycle strobe that captures `value_in`/`dp_in`.
- `hex_in` in 7: decoder output for `dig_bin`, active-low, combinational from `dig_bin`.
- `dig_bin` out 4: nibble of the current digit, registered, to decoder `bin_in`.
- `an_out` out 4: anode enables, active-low, registered.
- `seg_out` out 7: cathodes, active-low; `hex_in` gated by the registered blank flag.
- `dp_out` out 1: decimal point cathode, active-low, registered.
- `frame_tick` out 1: one-cycle pulse at every frame boundary.

## Operation
- Registers:
  - slot counter `cnt` (0..REFRESH_DIV-1)
  - digit index `idx` (0..3)
  - pending buffer `pend_val`/`pend_dp` plus `pend_vld`
  - display buffer `disp_val`/`disp_dp`
- FSM states:
  - IDLE: `enable`=0. `cnt`=0, `idx`=0, all anodes off, `seg_out`=7'h7F, `dp_out`=1.
  - DEAD: `cnt` < DEAD_CYCLES. Anodes all 1. `dig_bin` already shows the new digit so the decoder settles.
  - DRIVE: `cnt` ≥ DEAD_CYCLES. `an_out` = ~(1<<idx). `seg_out` = `hex_in`. `dp_out` = ~`disp_dp[idx]`.
- Transitions:
  - IDLE→DEAD when `enable`=1.
  - DEAD→DRIVE when `cnt`=DEAD_CYCLES-1.
  - DRIVE→DEAD when `cnt`=REFRESH_DIV-1, with `cnt`←0 and `idx`←idx+1 mod 4.
  - Any state→IDLE when `enable`=0, next cycle.
- Frame boundary: DRIVE, `cnt`=REFRESH_DIV-1, `idx`=3.
  - `frame_tick`=1 in the following cycle.
  - If `pend_vld`: `disp`←`pend`, `pend_vld`←0.
- `load`: `pend`←inputs, `pend_vld`←1; a later load overwrites an earlier one.
- `load` coincident with a frame boundary: `disp` takes `value_in`/`dp_in` directly and `pend_vld` stays 0.
- `load` while in IDLE: `disp` is updated immediately; there is no frame to tear.
- `dig_bin` = `disp_val[4*idx +: 4]`.

## Timing
- Reset values:
  - `an_out`=4'b1111, `seg_out`=7'h7F, `dp_out`=1, `dig_bin`=0, `frame_tick`=0
  - `cnt`=0, `idx`=0, `disp`=0, `pend`=0, `pend_vld`=0
  - state=IDLE
- Reset asserted mid-scan: all outputs go to reset values immediately (asynchronous).
- First anode assertion: DEAD_CYCLES+1 cycles after the first cycle of `enable`=1.
- Frame period: 4·REFRESH_DIV cycles. Digit slot: REFRESH_DIV cycles, of which REFRESH_DIV-DEAD_CYCLES are driven.
- Load-to-display latency: ≤ 4·REFRESH_DIV+1 cycles; 1 cycle at a coincident boundary.
- `enable` falling: anodes off on the next clock edge. Pending data is kept.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Digit k (k=3..1) is blanked when `disp_val` nibbles k..3 are all zero. Blanking means anode held high, `seg_out`=7'h7F, `dp_out`=1 for the whole slot.
  - Digit 0 is never blanked.
  - Slot timing is unchanged.
- Not defined: every digit is always driven, so zeros show as '0'.

## Test plan
All scenarios use REFRESH_DIV=8, DEAD_CYCLES=2.
- Reset, then `enable`=1, `load` with `value_in`=16'h1234. Required response:
  - from the next frame, digit slots 0..3 show `dig_bin` = 4,3,2,1
  - `an_out` = 1110, 1101, 1011, 0111, each low for 6 cycles after 2 dark cycles
  - `frame_tick` every 32 cycles
- With 16'hAAAA on display, `load` 16'h5555 while `idx`=1 → digits 1–3 still show A. 5 appears starting with slot 0 of the next frame.
- `load` 16'h00F0 exactly on the frame-boundary cycle → the very next slot 0 shows `dig_bin`=0 and slot 1 shows F.
- `enable` dropped mid-DRIVE → next cycle `an_out`=1111, `seg_out`=7F. Re-enable restarts at `idx`=0 with 2 dark cycles.
- `rst_n` pulsed low in slot 2 → all outputs return to reset values asynchronously and `disp`=0.
- With `LEADING_ZERO_BLANK_EN` defined, `value_in`=16'h0070 → digits 3 and 2 have anodes never asserted, digit 1 shows 7, digit 0 shows 0. With 16'h0000, only digit 0 is lit.
